lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Sequencer between the execute/memory stage and a handshaked data memory port. It accepts one load or store per request and decodes size/sign from funct3 (inst[14:12]). It drives the memory request until it is granted, waits for read data, and lane-aligns and sign/zero-extends load data. It stalls the pipeline while a transaction is outstanding and flags misaligned/illegal accesses and memory timeouts.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT_R before bus_err (>=2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  pipeline requests a memory op (held until done)
req_we  in  1  1=store, 0=load
req_funct3  in  3  inst[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2)
busy  out  1  stall pipeline
done  out  1  one-cycle completion pulse
misalign  out  1  valid with done: misaligned or illegal funct3
bus_err  out  1  valid with done: read timeout
ld_data  out  32  extended load result, held until next load completion
mem_req  out  1  request to DMEM
mem_we  out  1  write enable
mem_addr  out  32  word address {req_addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte write mask (0 for loads)
mem_gnt  in  1  DMEM accepts request this cycle
mem_rvalid  in  1  read data valid (earliest: cycle after gnt)
mem_rdata  in  32  read word

Behaviour:
- Reset: state IDLE; all outputs 0, including ld_data and counter.
- States: IDLE, ISSUE, WAIT_R, FIN.
- IDLE: when req_valid=1, latch we/funct3/addr/wdata.
  - Illegal access goes to FIN with misalign=1 and no mem_req. Illegal means: funct3 in {011,110,111}; store with funct3[2]=1; H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Otherwise go to ISSUE.
- ISSUE: mem_req=1. mem_we/mem_addr/mem_wdata/mem_wmask are registered and stable for the whole request.
  - mem_gnt=1 with store: go to FIN.
  - mem_gnt=1 with load: clear counter, go to WAIT_R.
  - No gnt: stay in ISSUE indefinitely.
- WAIT_R: mem_req=0, counter increments each cycle.
  - mem_rvalid=1: register extended data into ld_data, go to FIN.
  - Counter reaches TIMEOUT-1 without rvalid: go to FIN with bus_err=1; ld_data unchanged.
  - rvalid and timeout in the same cycle: rvalid wins, no error.
- FIN: done=1 for one cycle, then return to IDLE. misalign/bus_err are 1 only in FIN and only for the cause above. req_valid is not sampled in FIN.
- busy = (IDLE & req_valid) | ISSUE | WAIT_R. busy is 0 in FIN so the pipeline advances on that edge.
- Store lanes, with o = addr[1:0]:
  - SB: wmask = 4'b0001<<o, wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011<<o, wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'b1111, wdata as-is.
- Load extract: s = rdata >> (8*o).
  - 000: sext s[7:0]; 100: zext s[7:0].
  - 001: sext s[15:0]; 101: zext s[15:0].
  - 010: rdata.
- mem_rvalid outside WAIT_R is ignored. mem_gnt outside ISSUE is ignored.
- Latency with zero-wait memory:
  - Load: accept, ISSUE (gnt), WAIT_R (rvalid), FIN → done 3 cycles after accept edge.
  - Store: done 2 cycles after accept edge.
- Reset mid-operation (any state) returns to IDLE next edge; mem_req drops immediately; no done pulse. DMEM shares rst, so no stale response survives.
- Back-to-back requests: a new req_valid is accepted in the IDLE cycle following FIN.

Test Plan:
- LB addr 0x103, rdata 0x80FF_1234, gnt/rvalid immediate → mem_addr 0x100, wmask 0, ld_data 0xFFFF_FF80, done 3 cycles after accept, busy low in FIN.
- LHU addr 0x202, rdata 0xBEEF_0000 → ld_data 0x0000_BEEF; repeat as LH → 0xFFFF_BEEF.
- SB addr 0x301, wdata 0x0000_00AB, gnt delayed 4 cycles → mem_req held 5 cycles with mem_addr 0x300, wmask 0010, wdata 0xABAB_ABAB constant; done one cycle after gnt; rvalid ignored.
- LW addr 0x402, then SH addr 0x1, then funct3 011 → each gives done+misalign one cycle after accept, mem_req never asserted, ld_data unchanged.
- LW with gnt but no rvalid, TIMEOUT=16 → done+bus_err after 16 WAIT_R cycles; rvalid arriving exactly at the last count → ld_data updated, bus_err 0.
- rst asserted in WAIT_R → next cycle all outputs 0, state IDLE, no done; a following LW completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between the memory stage and a handshaked DMEM port
//
// Purpose: accepts one load or store per request, drives the DMEM request until it is
// granted, waits for read data with a timeout, and lane-aligns and extends load data.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   req_valid/we/funct3/addr/wdata   pipeline request (held until done)
//   busy, done                  stall and one-cycle completion pulse
//   misalign, bus_err           completion status, valid with done
//   ld_data                     extended load result, held until the next load completes
//   mem_req/we/addr/wdata/wmask DMEM request channel, stable while mem_req is high
//   mem_gnt                     DMEM accepts the request
//   mem_rvalid, mem_rdata       DMEM read response
module lsu_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] ld_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, FIN} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;

  logic        illegal;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [31:0] shifted;
  logic [31:0] ld_ext;

  // Decode legality of the incoming request.
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b001, 3'b101:         illegal = req_addr[0];
      3'b010:                 illegal = (req_addr[1:0] != 2'b00);
      default:                illegal = 1'b0;
    endcase
    if (req_we && req_funct3[2]) illegal = 1'b1;
  end

  // Store lane placement: data replicated across lanes, mask selects the target bytes.
  always_comb begin
    st_wdata = req_wdata;
    st_wmask = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wmask = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wmask = 4'b0011 << req_addr[1:0];
      end
      default: begin
        st_wdata = req_wdata;
        st_wmask = 4'b1111;
      end
    endcase
  end

  // Load extraction from the latched size/offset.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_ext = {24'h0, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_ext = {16'h0, shifted[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    ld_data_d   = ld_data_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d  = req_we;
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          if (illegal) begin
            misalign_d = 1'b1;
            state_d    = FIN;
          end else begin
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_we ? st_wdata : 32'h0;
            mem_wmask_d = req_we ? st_wmask : 4'b0000;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          if (we_q) begin
            state_d = FIN;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + 1'b1;
        // rvalid has priority over a timeout on the final count.
        if (mem_rvalid) begin
          ld_data_d = ld_ext;
          state_d   = FIN;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          bus_err_d = 1'b1;
          state_d   = FIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      ld_data_q   <= 32'h0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wmask_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      ld_data_q   <= ld_data_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  assign busy      = ((state_q == IDLE) && req_valid) || (state_q == ISSUE) || (state_q == WAIT_R);
  assign done      = (state_q == FIN);
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;
  assign ld_data   = ld_data_q;
  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl
module tb_lsu_ctrl;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, misalign, bus_err;
  logic [31:0] ld_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_ld;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .misalign(misalign), .bus_err(bus_err),
    .ld_data(ld_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load result: pick the byte/half by arithmetic and extend.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] o,
                                            input logic [31:0] rd);
    logic [31:0] s;
    s = rd / (32'h1 << (8 * o));
    case (f3)
      3'b000:  return (s & 32'hFF) - (((s & 32'h80) != 0) ? 32'h100 : 32'h0);
      3'b100:  return s & 32'hFF;
      3'b001:  return (s & 32'hFFFF) - (((s & 32'h8000) != 0) ? 32'h10000 : 32'h0);
      3'b101:  return s & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_wmask"}, 32'(mem_wmask), 32'h0);
    chk({tag, "_ld_data"}, ld_data, 32'h0);
    chk({tag, "_misalign"}, 32'(misalign), 32'h0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'h0);
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; returns likewise.
  // gdly: ISSUE cycles before grant; rdly: WAIT_R cycles before rvalid (>=TIMEOUT => none).
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int gdly, input int rdly);
    bit illegal, e_err, got_done;
    int exp_cyc, k, req_cnt, gnt_cyc;
    int o;
    logic [31:0] e_addr, e_wd, new_ld;
    logic [3:0]  e_mask;

    o = int'(addr[1:0]);
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
              ((f3[1:0] == 2'b01) && addr[0]) || ((f3 == 3'd2) && (o != 0));
    e_addr = addr & ~32'h3;
    e_mask = 4'h0;
    e_wd   = wd;
    if (we) begin
      case (f3[1:0])
        2'b00:   begin e_mask = 4'(1 << o); e_wd = wd[7:0] * 32'h0101_0101; end
        2'b01:   begin e_mask = 4'(3 << o); e_wd = wd[15:0] * 32'h0001_0001; end
        default: begin e_mask = 4'hF;       e_wd = wd; end
      endcase
    end
    e_err = 1'b0;
    if (illegal)              exp_cyc = 1;
    else if (we)              exp_cyc = gdly + 2;
    else if (rdly < TIMEOUT)  exp_cyc = gdly + 3 + rdly;
    else begin                exp_cyc = gdly + 2 + TIMEOUT; e_err = 1'b1; end
    new_ld = (!illegal && !we && !e_err) ? exp_load(f3, addr[1:0], rd) : model_ld;

    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("busy_accept", 32'(busy), 32'h1);

    k = 0; req_cnt = 0; gnt_cyc = -1; got_done = 1'b0;
    while (!got_done && k < 200) begin
      @(posedge clk); #1;
      k++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (done) begin
        got_done = 1'b1;
        chk("done_cycle", k, exp_cyc);
        chk("misalign", 32'(misalign), 32'(illegal));
        chk("bus_err", 32'(bus_err), 32'(e_err));
        chk("busy_fin", 32'(busy), 32'h0);
        chk("mem_req_fin", 32'(mem_req), 32'h0);
        chk("ld_data", ld_data, new_ld);
        req_valid = 1'b0;
      end else if (mem_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_wmask", 32'(mem_wmask), 32'(e_mask));
        if (we) chk("mem_wdata", mem_wdata, e_wd);
        if (req_cnt == gdly) begin
          mem_gnt = 1'b1;
          gnt_cyc = k;
        end else begin
          mem_rvalid = 1'b1;       // stray response, must be ignored
          mem_rdata  = ~rd;
        end
        req_cnt++;
      end else if (gnt_cyc >= 0 && !we && k == gnt_cyc + 1 + rdly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
      end
    end
    if (!got_done) chk("done_timeout", 32'h0, 32'h1);
    chk("mem_req_cycles", req_cnt, illegal ? 0 : gdly + 1);
    model_ld = new_ld;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    model_ld = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // LB sign-extended from the top byte
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
    chk("lb_literal", ld_data, 32'hFFFF_FF80);
    // LHU then LH on the upper half
    run_op(1'b0, 3'b101, 32'h202, 32'h0, 32'hBEEF_0000, 0, 0);
    chk("lhu_literal", ld_data, 32'h0000_BEEF);
    run_op(1'b0, 3'b001, 32'h202, 32'h0, 32'hBEEF_0000, 0, 0);
    chk("lh_literal", ld_data, 32'hFFFF_BEEF);
    // SB with grant delayed four cycles
    run_op(1'b1, 3'b000, 32'h301, 32'h0000_00AB, 32'h0, 4, 0);
    // Illegal accesses
    run_op(1'b0, 3'b010, 32'h402, 32'h0, 32'h0, 0, 0);
    run_op(1'b1, 3'b001, 32'h001, 32'h1234, 32'h0, 0, 0);
    run_op(1'b0, 3'b011, 32'h500, 32'h0, 32'h0, 0, 0);
    chk("illegal_ld_kept", ld_data, 32'hFFFF_BEEF);
    // Timeout, then rvalid exactly on the last count
    run_op(1'b0, 3'b010, 32'h400, 32'h0, 32'hDEAD_BEEF, 0, TIMEOUT);
    run_op(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFE_F00D, 1, TIMEOUT - 1);
    chk("last_count_ld", ld_data, 32'hCAFE_F00D);

    // Reset while in WAIT_R
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check_idle_zero("mid_reset");
    model_ld = 32'h0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_no_done", 32'(done), 32'h0);
    run_op(1'b0, 3'b010, 32'h700, 32'h0, 32'h1357_9BDF, 0, 1);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      int          r_rdly;
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_rdly = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
      run_op(r_we, r_f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), r_rdly);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
